mdio_arbiter: RTL and testbench
===============================

# mdio_arbiter

Round-robin arbiter and sequencer that shares one MDIO management engine among `NUM_REQ` independent requesters, such as link-monitor, PHY-init and host-register bridge. Each requester submits single read or write transactions over a valid/ready handshake. The arbiter serialises the transactions onto the engine's command port, waits for completion or a timeout, and routes the result back to the originating requester only. It sits between the requesters and the MDIO master/writer engine that drives `mdc`/`mdio`.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, range 2..8
- `TIMEOUT_CYCLES`, 4096: `clk` cycles allowed from command acceptance to `mst_done` before the transaction is aborted
Ports:
- `clk`  in  1  single clock domain
- `reset`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQ  per-requester command valid
- `req_ready`  out  NUM_REQ  per-requester command accepted; one-hot or zero
- `req_write`  in  NUM_REQ  1 = write, 0 = read
- `req_phy_addr`  in  NUM_REQ x 5  PHY address
- `req_reg_addr`  in  NUM_REQ x 5  register address
- `req_wdata`  in  NUM_REQ x 16  write data
- `rsp_valid`  out  NUM_REQ  one-cycle completion pulse; one-hot or zero
- `rsp_error`  out  1  timeout flag, qualified by any `rsp_valid`
- `rsp_rdata`  out  16  read data, qualified by any `rsp_valid`; 0 for writes and on error
- `mst_valid`  out  1  command valid to the engine
- `mst_ready`  in  1  engine accepts the command
- `mst_write`, `mst_phy_addr`, `mst_reg_addr`, `mst_wdata`  out  1/5/5/16  registered copy of the granted command
- `mst_done`  in  1  one-cycle engine completion pulse
- `mst_rdata`  in  16  engine read data, valid with `mst_done`

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- **IDLE**
  - When any `req_valid` is set, grant the first requester at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
  - Pulse `req_ready[g]`, latch the command into the `mst_*` registers, then go to ISSUE.
- **ISSUE**
  - Hold `mst_valid`=1 with stable fields until `mst_ready`.
  - On `mst_ready`, clear the timeout counter and go to WAIT.
- **WAIT**
  - Count cycles.
  - On `mst_done`, latch `mst_rdata`, masked to 0 for writes, with `rsp_error`=0.
  - If the count reaches `TIMEOUT_CYCLES`-1 without `mst_done`, latch `rsp_rdata`=0 with `rsp_error`=1.
  - Either event moves to RESPOND.
- **RESPOND**
  - Assert `rsp_valid[g]` for exactly one cycle.
  - Set `rr_ptr` = (g+1) mod `NUM_REQ`, then return to IDLE.
- Only one transaction is outstanding at a time; there is no queueing inside the block.
- A requester must hold `req_valid` and its fields stable until `req_ready`. Dropping `req_valid` early is legal only while not granted.
- A `mst_done` pulse outside WAIT is ignored.
- If `mst_done` and the timeout fire in the same cycle, `mst_done` wins and `rsp_error`=0.
- The `req_*` fields of non-granted requesters are never sampled.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_error`=0, `rsp_rdata`=0, `mst_valid`=0, all `mst_*` fields 0, `rr_ptr`=0, state IDLE.
- All outputs are registered.
- Grant latency: `req_valid` sampled high in IDLE gives `req_ready` the next cycle. `mst_valid` rises in the same cycle as `req_ready`.
- Completion: `mst_done` in cycle N gives `rsp_valid` in cycle N+1.
- Minimum spacing between back-to-back transactions is 4 cycles, assuming `mst_ready` is already high and `mst_done` arrives immediately.
- Timeout counter is `$clog2(TIMEOUT_CYCLES)` bits wide and does not wrap.
- Reset asserted mid-transaction:
  - All outputs return to reset values immediately, asynchronously.
  - The in-flight transaction is dropped and no `rsp_valid` is issued.
  - The engine is expected to be reset by the same signal.

## Structure
- Shared package `mdio_pkg` holds:
  - `mdio_cmd_t` struct: write, phy_addr[4:0], reg_addr[4:0], wdata[15:0]
  - `mdio_arb_state_t` enum
  - width constants `MDIO_ADDR_W`=5 and `MDIO_DATA_W`=16
- One natural sub-module, `rr_grant`: combinational round-robin priority picker taking `req` and `ptr` and producing a one-hot `grant`. It is also reusable elsewhere.

## Test plan
- **Single read:** req 2 reads phy 0x0c reg 0x01; engine returns 0x796d.
  - `rsp_valid`=4'b0100, `rsp_rdata`=0x796d, `rsp_error`=0.
  - `mst_phy_addr`=0x0c.
- **Fairness:** all 4 requesters held valid from reset.
  - Grant order is 0,1,2,3,0, with `rr_ptr` wrapping correctly.
- **Write:** req 1 writes 0x1140 to reg 0x00.
  - `mst_wdata`=0x1140, `mst_write`=1.
  - `rsp_rdata`=0 even if the engine drives 0xFFFF on `mst_rdata`.
- **Timeout:** engine never pulses `mst_done`, with `TIMEOUT_CYCLES`=16.
  - `rsp_valid` arrives exactly 17 cycles after `mst_ready`, with `rsp_error`=1 and `rsp_rdata`=0.
- **Backpressure plus simultaneous events:** `mst_ready` low for 10 cycles.
  - `mst_*` stays stable throughout.
  - A `mst_done` arriving on the same cycle as the timeout gives `rsp_error`=0.
- **Reset mid-WAIT:** `reset` driven low for 2 cycles.
  - All outputs read 0 asynchronously and no `rsp_valid` is issued.
  - The next request is granted normally, starting from requester 0.

Source files
------------

// File: rtl/mdio_pkg.sv
`default_nettype none
// =====================================================================
// mdio_pkg : shared types and widths for the MDIO arbiter slice
// Rev 1.0
// =====================================================================
package mdio_pkg;

    localparam int MDIO_ADDR_W = 5;
    localparam int MDIO_DATA_W = 16;

    typedef struct packed {
        logic                   write;
        logic [MDIO_ADDR_W-1:0] phy_addr;
        logic [MDIO_ADDR_W-1:0] reg_addr;
        logic [MDIO_DATA_W-1:0] wdata;
    } mdio_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } mdio_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_grant.sv
`default_nettype none
// =====================================================================
// rr_grant : combinational round-robin picker, first req at/after ptr
// Rev 1.0
// =====================================================================
module rr_grant #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic [PTR_W:0] idx;

    // Walk from lowest to highest priority so the last hit (offset 0) wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (PTR_W + 1)'(k);
            if (idx >= (PTR_W + 1)'(NUM_REQ)) begin
                idx = idx - (PTR_W + 1)'(NUM_REQ);
            end
            if (req[idx[PTR_W-1:0]]) begin
                grant                 = '0;
                grant[idx[PTR_W-1:0]] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdio_arbiter.sv
`default_nettype none
// =====================================================================
// mdio_arbiter : round-robin sequencer sharing one MDIO engine
// Rev 1.0
// =====================================================================
module mdio_arbiter
    import mdio_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ-1:0]                  req_write,
    input  logic [NUM_REQ-1:0][MDIO_ADDR_W-1:0] req_phy_addr,
    input  logic [NUM_REQ-1:0][MDIO_ADDR_W-1:0] req_reg_addr,
    input  logic [NUM_REQ-1:0][MDIO_DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic                                rsp_error,
    output logic [MDIO_DATA_W-1:0]              rsp_rdata,
    output logic                                mst_valid,
    input  logic                                mst_ready,
    output logic                                mst_write,
    output logic [MDIO_ADDR_W-1:0]              mst_phy_addr,
    output logic [MDIO_ADDR_W-1:0]              mst_reg_addr,
    output logic [MDIO_DATA_W-1:0]              mst_wdata,
    input  logic                                mst_done,
    input  logic [MDIO_DATA_W-1:0]              mst_rdata
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    mdio_arb_state_t    state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   nxt_ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] grant_q;
    logic [TMO_W-1:0]   tmo_cnt;
    mdio_cmd_t          sel_cmd;
    mdio_cmd_t          cmd_q;

    rr_grant #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_grant (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Only the granted requester's fields reach the command register.
    always_comb begin
        grant_idx = '0;
        sel_cmd   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx        = PTR_W'(i);
                sel_cmd.write    = req_write[i];
                sel_cmd.phy_addr = req_phy_addr[i];
                sel_cmd.reg_addr = req_reg_addr[i];
                sel_cmd.wdata    = req_wdata[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            nxt_ptr   <= '0;
            grant_q   <= '0;
            tmo_cnt   <= '0;
            cmd_q     <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
            mst_valid <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        req_ready <= grant;
                        grant_q   <= grant;
                        nxt_ptr   <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                                         : grant_idx + PTR_W'(1);
                        cmd_q     <= sel_cmd;
                        mst_valid <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mst_ready) begin
                        mst_valid <= 1'b0;
                        tmo_cnt   <= '0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A completion in the timeout cycle still counts as success.
                    if (mst_done) begin
                        rsp_rdata <= cmd_q.write ? '0 : mst_rdata;
                        rsp_error <= 1'b0;
                        rsp_valid <= grant_q;
                        state     <= ST_RESPOND;
                    end else if (tmo_cnt == TMO_LAST) begin
                        rsp_rdata <= '0;
                        rsp_error <= 1'b1;
                        rsp_valid <= grant_q;
                        state     <= ST_RESPOND;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_RESPOND: begin
                    rr_ptr <= nxt_ptr;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mst_write    = cmd_q.write;
    assign mst_phy_addr = cmd_q.phy_addr;
    assign mst_reg_addr = cmd_q.reg_addr;
    assign mst_wdata    = cmd_q.wdata;

endmodule
`default_nettype wire

// File: tb/tb_mdio_arbiter.sv
`default_nettype none
// =====================================================================
// tb_mdio_arbiter : randomized self-checking bench with a transaction-level model
// Rev 1.0
// =====================================================================
module tb_mdio_arbiter;
    import mdio_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        req_valid, req_ready, req_write, rsp_valid;
    logic [N-1:0][4:0]   req_phy_addr, req_reg_addr;
    logic [N-1:0][15:0]  req_wdata;
    logic                rsp_error;
    logic [15:0]         rsp_rdata;
    logic                mst_valid, mst_ready, mst_write, mst_done;
    logic [4:0]          mst_phy_addr, mst_reg_addr;
    logic [15:0]         mst_wdata, mst_rdata;
    logic [52:0]         all_outs;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;
    int cyc = 0;

    logic [N-1:0] cap_grant, cap_rv;
    logic         cap_write, cap_err, cap_mv_wait;
    logic [4:0]   cap_pa, cap_ra;
    logic [15:0]  cap_wd, cap_rdata;
    bit           cap_hold_ok;
    int           cap_lat, cap_gcyc;

    mdio_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_phy_addr (req_phy_addr),
        .req_reg_addr (req_reg_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_error    (rsp_error),
        .rsp_rdata    (rsp_rdata),
        .mst_valid    (mst_valid),
        .mst_ready    (mst_ready),
        .mst_write    (mst_write),
        .mst_phy_addr (mst_phy_addr),
        .mst_reg_addr (mst_reg_addr),
        .mst_wdata    (mst_wdata),
        .mst_done     (mst_done),
        .mst_rdata    (mst_rdata)
    );

    assign all_outs = {req_ready, rsp_valid, rsp_error, rsp_rdata, mst_valid,
                       mst_write, mst_phy_addr, mst_reg_addr, mst_wdata};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Round-robin rule: first pending requester at or after the pointer, wrapping.
    function automatic int model_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] one;
        one = 1;
        return (i < 0) ? '0 : (one << i);
    endfunction

    task automatic set_req(input int i, input logic w, input logic [4:0] pa,
                           input logic [4:0] ra, input logic [15:0] wd);
        req_write[i]    = w;
        req_phy_addr[i] = pa;
        req_reg_addr[i] = ra;
        req_wdata[i]    = wd;
    endtask

    // Engine model: stalls mst_ready, pulses mst_done in WAIT cycle done_cyc
    // (counted from the handshake, -1 = never), and records what it observed.
    task automatic engine_serve(input int ready_dly, input int done_cyc, input int junk_at,
                                input logic [15:0] rd, input bit hold);
        bit got;
        got = 0;
        cap_hold_ok = 1; cap_grant = '0; cap_lat = -1; cap_rv = '0;
        cap_err = 1'b0; cap_rdata = '0; cap_mv_wait = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mst_valid === 1'b1) begin got = 1; break; end
        end
        if (!got) return;
        cap_gcyc = cyc; cap_grant = req_ready; cap_write = mst_write;
        cap_pa = mst_phy_addr; cap_ra = mst_reg_addr; cap_wd = mst_wdata;
        if (!hold) req_valid = req_valid & ~req_ready;
        for (int d = 0; d < ready_dly; d++) begin
            mst_done = (d == junk_at);
            @(negedge clk);
            if (mst_valid !== 1'b1 || req_ready !== '0 || mst_write !== cap_write ||
                mst_phy_addr !== cap_pa || mst_reg_addr !== cap_ra || mst_wdata !== cap_wd)
                cap_hold_ok = 0;
        end
        mst_done  = 1'b0;
        mst_ready = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) cap_mv_wait = mst_valid;
            if (rsp_valid !== '0) begin
                cap_lat = c; cap_rv = rsp_valid; cap_err = rsp_error; cap_rdata = rsp_rdata;
                break;
            end
            mst_ready = 1'b0;
            mst_done  = (c == done_cyc);
            mst_rdata = (c == done_cyc) ? rd : 16'($urandom);
        end
        mst_done  = 1'b0;
        mst_ready = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = '0; req_write = '0; req_phy_addr = '0; req_reg_addr = '0; req_wdata = '0;
        mst_ready = 1'b0; mst_done = 1'b0; mst_rdata = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (all_outs !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== '0 || mst_valid !== 1'b0) begin
            errors++; $display("FAIL reset_idle: req_ready=%b mst_valid=%b expected 0/0", req_ready, mst_valid);
        end
        model_ptr = 0;
    endtask

    task automatic test_fairness();
        int exp, prev;
        prev = 0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 5'($urandom), 5'($urandom), 16'($urandom));
        req_valid = '1;
        for (int t = 0; t < 5; t++) begin
            exp = model_pick(req_valid, model_ptr);
            engine_serve(0, 1, -1, 16'($urandom), 1'b1);
            checks++;
            if (cap_grant !== onehot(exp)) begin
                errors++; $display("FAIL fair_grant[%0d]: got %b expected %b", t, cap_grant, onehot(exp));
            end
            checks++;
            if (cap_rv !== onehot(exp)) begin
                errors++; $display("FAIL fair_rsp[%0d]: got %b expected %b", t, cap_rv, onehot(exp));
            end
            if (t > 0) begin
                checks++;
                if (cap_gcyc - prev != 4) begin
                    errors++; $display("FAIL fair_spacing[%0d]: got %0d expected 4", t, cap_gcyc - prev);
                end
            end
            prev = cap_gcyc;
            model_ptr = (exp + 1) % N;
        end
        req_valid = '0;
    endtask

    task automatic test_single_read();
        set_req(2, 1'b0, 5'h0c, 5'h01, 16'($urandom));
        req_valid = 4'b0100;
        engine_serve(0, 2, -1, 16'h796d, 1'b0);
        checks++;
        if ({cap_rv, cap_err, cap_rdata} !== {4'b0100, 1'b0, 16'h796d}) begin
            errors++; $display("FAIL read_rsp: got v=%b e=%b d=%h expected v=0100 e=0 d=796d", cap_rv, cap_err, cap_rdata);
        end
        checks++;
        if ({cap_write, cap_pa, cap_ra} !== {1'b0, 5'h0c, 5'h01}) begin
            errors++; $display("FAIL read_cmd: got w=%b pa=%h ra=%h expected w=0 pa=0c ra=01", cap_write, cap_pa, cap_ra);
        end
        checks++;
        if (cap_lat != 3 || cap_mv_wait !== 1'b0) begin
            errors++; $display("FAIL read_timing: got lat=%0d mst_valid_in_wait=%b expected 3/0", cap_lat, cap_mv_wait);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== '0) begin
            errors++; $display("FAIL read_pulse_width: got %b expected 0000", rsp_valid);
        end
        model_ptr = 3;
    endtask

    task automatic test_write();
        set_req(1, 1'b1, 5'($urandom), 5'h00, 16'h1140);
        req_valid = 4'b0010;
        engine_serve(1, 1, -1, 16'hFFFF, 1'b0);
        checks++;
        if ({cap_write, cap_ra, cap_wd} !== {1'b1, 5'h00, 16'h1140}) begin
            errors++; $display("FAIL write_cmd: got w=%b ra=%h wd=%h expected w=1 ra=00 wd=1140", cap_write, cap_ra, cap_wd);
        end
        checks++;
        if ({cap_rv, cap_err, cap_rdata} !== {4'b0010, 1'b0, 16'h0000}) begin
            errors++; $display("FAIL write_rsp: got v=%b e=%b d=%h expected v=0010 e=0 d=0000", cap_rv, cap_err, cap_rdata);
        end
        model_ptr = 2;
    endtask

    task automatic test_timeout();
        set_req(3, 1'b0, 5'($urandom), 5'($urandom), 16'($urandom));
        req_valid = 4'b1000;
        engine_serve(0, -1, -1, 16'hBEEF, 1'b0);
        checks++;
        if (cap_lat != TMO + 1) begin
            errors++; $display("FAIL timeout_latency: got %0d expected %0d", cap_lat, TMO + 1);
        end
        checks++;
        if ({cap_rv, cap_err, cap_rdata} !== {4'b1000, 1'b1, 16'h0000}) begin
            errors++; $display("FAIL timeout_rsp: got v=%b e=%b d=%h expected v=1000 e=1 d=0000", cap_rv, cap_err, cap_rdata);
        end
        model_ptr = 0;
    endtask

    task automatic test_backpressure();
        logic [15:0] rd;
        rd = 16'($urandom) | 16'h0001;
        set_req(0, 1'b0, 5'($urandom), 5'($urandom), 16'($urandom));
        req_valid = 4'b0001;
        engine_serve(10, TMO, 4, rd, 1'b0);
        checks++;
        if (!cap_hold_ok) begin
            errors++; $display("FAIL bp_stable: got unstable mst_* during stall expected stable");
        end
        checks++;
        if (cap_lat != TMO + 1) begin
            errors++; $display("FAIL bp_latency: got %0d expected %0d", cap_lat, TMO + 1);
        end
        checks++;
        if ({cap_rv, cap_err, cap_rdata} !== {4'b0001, 1'b0, rd}) begin
            errors++; $display("FAIL bp_done_wins: got v=%b e=%b d=%h expected v=0001 e=0 d=%h", cap_rv, cap_err, cap_rdata, rd);
        end
        model_ptr = 1;
    endtask

    task automatic test_reset_mid_wait();
        bit got, seen;
        int exp;
        set_req(1, 1'b0, 5'($urandom), 5'($urandom), 16'($urandom));
        req_valid = 4'b0010;
        engine_serve(0, 1, -1, 16'($urandom), 1'b0);
        checks++;
        if (cap_rv !== 4'b0010) begin
            errors++; $display("FAIL rst_pre_rsp: got %b expected 0010", cap_rv);
        end
        model_ptr = 2;
        set_req(2, 1'b0, 5'($urandom), 5'($urandom), 16'($urandom));
        req_valid = 4'b0100;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mst_valid === 1'b1) begin got = 1; break; end
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL rst_grant_wait: got no mst_valid expected grant within 20 cycles");
        end
        req_valid = '0;
        mst_ready = 1'b1;
        @(negedge clk);
        mst_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (all_outs !== '0) begin
            errors++; $display("FAIL rst_async: got %h expected 0", all_outs);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            mst_done = (k == 2);
            @(negedge clk);
            if (rsp_valid !== '0) seen = 1;
        end
        mst_done = 1'b0;
        checks++;
        if (seen) begin
            errors++; $display("FAIL rst_no_rsp: got rsp_valid after reset expected none");
        end
        model_ptr = 0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 5'($urandom), 5'($urandom), 16'($urandom));
        req_valid = '1;
        exp = model_pick(req_valid, model_ptr);
        engine_serve(0, 1, -1, 16'($urandom), 1'b0);
        checks++;
        if (cap_grant !== onehot(exp) || cap_rv !== onehot(exp)) begin
            errors++; $display("FAIL rst_regrant: got g=%b v=%b expected %b", cap_grant, cap_rv, onehot(exp));
        end
        model_ptr = (exp + 1) % N;
        req_valid = '0;
    endtask

    task automatic test_random();
        int exp, rdy, dc, r, exp_lat;
        logic [15:0] rd, exp_rd;
        logic e_w, exp_err;
        logic [4:0] e_pa, e_ra;
        logic [15:0] e_wd;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    set_req(i, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
                    req_valid[i] = 1'b1;
                end
            end
            if (req_valid == '0) begin
                r = $urandom_range(0, N - 1);
                set_req(r, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
                req_valid[r] = 1'b1;
            end
            exp  = model_pick(req_valid, model_ptr);
            e_w  = req_write[exp];
            e_pa = req_phy_addr[exp];
            e_ra = req_reg_addr[exp];
            e_wd = req_wdata[exp];
            rdy  = $urandom_range(0, 3);
            dc   = $urandom_range(1, 20);
            rd   = 16'($urandom);
            engine_serve(rdy, dc, -1, rd, 1'b0);
            exp_err = (dc > TMO);
            exp_lat = exp_err ? TMO + 1 : dc + 1;
            exp_rd  = (exp_err || e_w) ? 16'h0000 : rd;
            checks++;
            if ({cap_grant, cap_write, cap_pa, cap_ra, cap_wd} !== {onehot(exp), e_w, e_pa, e_ra, e_wd}) begin
                errors++; $display("FAIL rand_cmd[%0d]: got g=%b w=%b pa=%h ra=%h wd=%h expected g=%b w=%b pa=%h ra=%h wd=%h",
                                   it, cap_grant, cap_write, cap_pa, cap_ra, cap_wd, onehot(exp), e_w, e_pa, e_ra, e_wd);
            end
            checks++;
            if ({cap_rv, cap_err, cap_rdata} !== {onehot(exp), exp_err, exp_rd}) begin
                errors++; $display("FAIL rand_rsp[%0d]: got v=%b e=%b d=%h expected v=%b e=%b d=%h",
                                   it, cap_rv, cap_err, cap_rdata, onehot(exp), exp_err, exp_rd);
            end
            checks++;
            if (cap_lat != exp_lat) begin
                errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", it, cap_lat, exp_lat);
            end
            model_ptr = (exp + 1) % N;
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single_read();
        test_write();
        test_timeout();
        test_backpressure();
        test_reset_mid_wait();
        test_random();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
